mul8_seq_ctrl: RTL and testbench

- Sequencer that performs 8x8 unsigned multiplication using one external 4x4 combinational multiplier core.
- Splits each operand into nibbles and issues up to four 4x4 partial products to the core, one per cycle.
- Shifts each partial product into place and accumulates it into a 16-bit result.
- Has a valid/ready handshake on both the operand and result sides. It sits between the register or IO front-end and the 4x4 core.

---
 rtl/mul8_seq_ctrl.sv | 150 +++++++++++++++
 tb/tb_mul8_seq_ctrl.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/mul8_seq_ctrl.sv
// Sequential 8x8 unsigned multiplier controller driving an external 4x4 core.
// Issues up to four nibble partial products, shifts and accumulates them into a 16-bit result.
module mul8_seq_ctrl #(
  parameter bit ZERO_SKIP = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [7:0]  in_a,
  input  logic [7:0]  in_b,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_p,
  output logic [3:0]  mul_m,
  output logic [3:0]  mul_q,
  input  logic [7:0]  mul_p,
  output logic        mul_en,
  output logic        busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state_reg, state_next;
  logic [7:0]  a_reg, a_next;
  logic [7:0]  b_reg, b_next;
  logic [3:0]  mask_reg, mask_next;
  logic [15:0] acc_reg, acc_next;

  logic [3:0]  step_m [4];
  logic [3:0]  step_q [4];
  logic [15:0] step_term [4];
  logic [3:0]  new_mask;
  logic [3:0]  cur_onehot;
  logic [3:0]  cur_m, cur_q;
  logic [15:0] cur_term;

  // Step k: multiplicand nibble = a[k%2], multiplier nibble = b[k/2], shift = 4*(k%2 + k/2).
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_step
      localparam int SHIFT = 4 * ((gi % 2) + (gi / 2));
      logic [3:0] in_m_nib, in_q_nib;

      if (gi % 2 == 1) begin : g_hi_m
        assign step_m[gi] = a_reg[7:4];
        assign in_m_nib   = in_a[7:4];
      end else begin : g_lo_m
        assign step_m[gi] = a_reg[3:0];
        assign in_m_nib   = in_a[3:0];
      end

      if (gi / 2 == 1) begin : g_hi_q
        assign step_q[gi] = b_reg[7:4];
        assign in_q_nib   = in_b[7:4];
      end else begin : g_lo_q
        assign step_q[gi] = b_reg[3:0];
        assign in_q_nib   = in_b[3:0];
      end

      assign step_term[gi] = {8'b0, mul_p} << SHIFT;
      assign new_mask[gi]  = ZERO_SKIP ? ((|in_m_nib) && (|in_q_nib)) : 1'b1;
    end
  endgenerate

  // The current step is always the lowest bit still set in the mask.
  assign cur_onehot = mask_reg & (~mask_reg + 4'd1);

  always_comb begin
    cur_m    = 4'd0;
    cur_q    = 4'd0;
    cur_term = 16'd0;
    for (int k = 0; k < 4; k++) begin
      if (cur_onehot[k]) begin
        cur_m    = step_m[k];
        cur_q    = step_q[k];
        cur_term = step_term[k];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
      a_reg     <= 8'd0;
      b_reg     <= 8'd0;
      mask_reg  <= 4'd0;
      acc_reg   <= 16'd0;
    end else begin
      state_reg <= state_next;
      a_reg     <= a_next;
      b_reg     <= b_next;
      mask_reg  <= mask_next;
      acc_reg   <= acc_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    a_next     = a_reg;
    b_next     = b_reg;
    mask_next  = mask_reg;
    acc_next   = acc_reg;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    out_p      = 16'd0;
    mul_m      = 4'd0;
    mul_q      = 4'd0;
    mul_en     = 1'b0;
    busy       = 1'b1;

    unique case (state_reg)
      IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        if (in_valid) begin
          a_next     = in_a;
          b_next     = in_b;
          acc_next   = 16'd0;
          mask_next  = new_mask;
          state_next = (|new_mask) ? MUL : DONE;
        end
      end
      MUL: begin
        mul_en    = 1'b1;
        mul_m     = cur_m;
        mul_q     = cur_q;
        acc_next  = acc_reg + cur_term;
        mask_next = mask_reg & ~cur_onehot;
        if (mask_next == 4'd0) begin
          state_next = DONE;
        end
      end
      DONE: begin
        out_valid = 1'b1;
        out_p     = acc_reg;
        if (out_ready) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_mul8_seq_ctrl.sv
// Bench for mul8_seq_ctrl: two instances (ZERO_SKIP=0 and 1), a queue-of-steps reference model
// checked every cycle, plus directed vectors with hand-computed results.
module tb_mul8_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid  [2];
  logic        in_ready  [2];
  logic [7:0]  in_a      [2];
  logic [7:0]  in_b      [2];
  logic        out_valid [2];
  logic        out_ready [2];
  logic [15:0] out_p     [2];
  logic [3:0]  mul_m     [2];
  logic [3:0]  mul_q     [2];
  logic [7:0]  mul_p     [2];
  logic        mul_en    [2];
  logic        busy      [2];

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  mul8_seq_ctrl #(.ZERO_SKIP(1'b0)) dut0 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid[0]), .in_ready(in_ready[0]), .in_a(in_a[0]), .in_b(in_b[0]),
    .out_valid(out_valid[0]), .out_ready(out_ready[0]), .out_p(out_p[0]),
    .mul_m(mul_m[0]), .mul_q(mul_q[0]), .mul_p(mul_p[0]), .mul_en(mul_en[0]), .busy(busy[0])
  );

  mul8_seq_ctrl #(.ZERO_SKIP(1'b1)) dut1 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid[1]), .in_ready(in_ready[1]), .in_a(in_a[1]), .in_b(in_b[1]),
    .out_valid(out_valid[1]), .out_ready(out_ready[1]), .out_p(out_p[1]),
    .mul_m(mul_m[1]), .mul_q(mul_q[1]), .mul_p(mul_p[1]), .mul_en(mul_en[1]), .busy(busy[1])
  );

  // External 4x4 core
  assign mul_p[0] = {4'b0, mul_m[0]} * {4'b0, mul_q[0]};
  assign mul_p[1] = {4'b0, mul_m[1]} * {4'b0, mul_q[1]};

  task automatic check(input string name, input int d, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s dut%0d: got %0h expected %0h at %0t", name, d, act, exp, $time);
    end
  endtask

  // Reference model: 0=waiting for operands, 1=issuing listed steps, 2=holding result
  int          m_state [2] = '{0, 0};
  int          m_cnt   [2] = '{0, 0};
  int          m_idx   [2] = '{0, 0};
  logic [3:0]  m_sm    [2][4];
  logic [3:0]  m_sq    [2][4];
  logic [15:0] m_prod  [2];

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int d = 0; d < 2; d++) m_state[d] = 0;
    end else begin
      for (int d = 0; d < 2; d++) begin
        case (m_state[d])
          0: if (in_valid[d]) begin
            logic [3:0] na [4];
            logic [3:0] nb [4];
            na = '{in_a[d][3:0], in_a[d][7:4], in_a[d][3:0], in_a[d][7:4]};
            nb = '{in_b[d][3:0], in_b[d][3:0], in_b[d][7:4], in_b[d][7:4]};
            m_prod[d] = 16'(in_a[d]) * 16'(in_b[d]);
            m_cnt[d]  = 0;
            m_idx[d]  = 0;
            for (int s = 0; s < 4; s++) begin
              if (d == 0 || (na[s] != 4'd0 && nb[s] != 4'd0)) begin
                m_sm[d][m_cnt[d]] = na[s];
                m_sq[d][m_cnt[d]] = nb[s];
                m_cnt[d]++;
              end
            end
            m_state[d] = (m_cnt[d] == 0) ? 2 : 1;
          end
          1: begin
            m_idx[d]++;
            if (m_idx[d] >= m_cnt[d]) m_state[d] = 2;
          end
          default: if (out_ready[d]) m_state[d] = 0;
        endcase
      end
    end
  end

  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      logic       working;
      logic [3:0] em, eq;
      working = (m_state[d] == 1) && (m_idx[d] < 4);
      em = working ? m_sm[d][m_idx[d]] : 4'd0;
      eq = working ? m_sq[d][m_idx[d]] : 4'd0;
      check("in_ready",  d, in_ready[d],  m_state[d] == 0);
      check("out_valid", d, out_valid[d], m_state[d] == 2);
      check("out_p",     d, out_p[d],     (m_state[d] == 2) ? m_prod[d] : 16'd0);
      check("mul_en",    d, mul_en[d],    m_state[d] == 1);
      check("mul_m",     d, mul_m[d],     em);
      check("mul_q",     d, mul_q[d],     eq);
      check("busy",      d, busy[d],      m_state[d] != 0);
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  // exp_seq packs the issued (m,q) nibble pairs, first step in the most significant used byte
  task automatic do_op(input int d, input logic [7:0] a, input logic [7:0] b, input logic [15:0] exp_p,
                       input int exp_n, input logic [31:0] exp_seq, input int hold);
    int got, k, n;
    logic [31:0] seq;
    in_a[d] = a; in_b[d] = b; in_valid[d] = 1'b1; out_ready[d] = 1'b0;
    got = 0;
    for (int i = 0; i < 20 && got == 0; i++) begin
      if (in_ready[d]) got = 1;
      step();
    end
    check("accept", d, got, 1);
    in_valid[d] = 1'b0; in_a[d] = ~a; in_b[d] = b ^ 8'h5A;
    k = 0; n = 0; seq = 0;
    while (!out_valid[d] && k < 20) begin
      if (mul_en[d]) begin
        n++;
        seq = {seq[23:0], mul_m[d], mul_q[d]};
      end
      step();
      k++;
    end
    check("mul_en_cycles", d, n, exp_n);
    check("mul_seq", d, seq, exp_seq);
    check("valid_edges", d, k + 1, exp_n + 1);
    check("result", d, out_p[d], exp_p);
    for (int i = 0; i < hold; i++) begin
      check("hold_p", d, out_p[d], exp_p);
      check("hold_valid", d, out_valid[d], 1);
      check("hold_in_ready", d, in_ready[d], 0);
      in_valid[d] = (i % 2 == 0);
      step();
    end
    in_valid[d] = 1'b0; out_ready[d] = 1'b1;
    step();
    check("after_valid", d, out_valid[d], 0);
    check("after_p", d, out_p[d], 0);
    check("after_in_ready", d, in_ready[d], 1);
    out_ready[d] = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int acc_n, res_n, acc2_cyc, hand1_cyc, cyc;
    logic [15:0] res [2];
    for (int d = 0; d < 2; d++) begin
      in_valid[d] = 1'b0; in_a[d] = 8'h00; in_b[d] = 8'h00; out_ready[d] = 1'b0;
    end
    step();
    for (int d = 0; d < 2; d++) begin
      check("rst_in_ready", d, in_ready[d], 1);
      check("rst_out_valid", d, out_valid[d], 0);
      check("rst_busy", d, busy[d], 0);
    end
    step();
    rst = 1'b0;
    step();

    do_op(0, 8'hFF, 8'hFF, 16'hFE01, 4, 32'hFFFF_FFFF, 0);
    do_op(0, 8'h12, 8'h34, 16'h03A8, 4, 32'h2414_2313, 10);
    do_op(1, 8'h10, 8'h01, 16'h0010, 1, 32'h0000_0011, 0);
    do_op(1, 8'h00, 8'h5A, 16'h0000, 0, 32'h0000_0000, 0);
    do_op(1, 8'h12, 8'h34, 16'h03A8, 4, 32'h2414_2313, 0);

    // Abort during the second MUL step
    in_a[0] = 8'hAB; in_b[0] = 8'hCD; in_valid[0] = 1'b1;
    step();
    in_valid[0] = 1'b0;
    step();
    check("abort_in_mul", 0, mul_en[0], 1);
    check("abort_second_step", 0, {mul_m[0], mul_q[0]}, 8'hAD);
    #1 rst = 1'b1;
    #1;
    check("abort_in_ready", 0, in_ready[0], 1);
    check("abort_out_valid", 0, out_valid[0], 0);
    check("abort_out_p", 0, out_p[0], 0);
    check("abort_mul_en", 0, mul_en[0], 0);
    check("abort_mul_mq", 0, {mul_m[0], mul_q[0]}, 0);
    check("abort_busy", 0, busy[0], 0);
    step();
    rst = 1'b0;
    repeat (6) step();
    check("abort_no_result", 0, out_valid[0], 0);
    do_op(0, 8'hAB, 8'hCD, 16'h88EF, 4, 32'hBDAD_BCAC, 0);

    // Back-to-back with in_valid held high
    in_a[0] = 8'h03; in_b[0] = 8'h05; in_valid[0] = 1'b1; out_ready[0] = 1'b1;
    acc_n = 0; res_n = 0; acc2_cyc = -100; hand1_cyc = 0; cyc = 0;
    res[0] = 16'hxxxx; res[1] = 16'hxxxx;
    while (res_n < 2 && cyc < 40) begin
      logic acc_now, hand_now;
      acc_now  = in_valid[0] && in_ready[0];
      hand_now = out_valid[0] && out_ready[0];
      if (hand_now) begin
        res[res_n] = out_p[0];
        if (res_n == 0) hand1_cyc = cyc;
        res_n++;
      end
      if (acc_now) begin
        acc_n++;
        if (acc_n == 2) acc2_cyc = cyc;
      end
      step();
      cyc++;
      if (acc_now && acc_n == 1) begin
        in_a[0] = 8'h07; in_b[0] = 8'h09;
      end
      if (acc_now && acc_n == 2) in_valid[0] = 1'b0;
    end
    check("b2b_first", 0, res[0], 16'h000F);
    check("b2b_second", 0, res[1], 16'h003F);
    check("b2b_accept_gap", 0, acc2_cyc, hand1_cyc + 1);
    out_ready[0] = 1'b0;
    repeat (3) step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
